// File: rtl/regbus_pkg.sv
// rtl/regbus_pkg.sv - shared state encoding, widths and request-field type for the register-bus arbiter
package regbus_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int REQ_W  = 1;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Everything a master presents alongside its req pulse.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_fields_t;

endpackage

// File: rtl/regbus_req_hold.sv
// rtl/regbus_req_hold.sv - per-master pending bit plus captured request fields
//   clk, rstn : clock, asynchronous active-low reset
//   req       : single-cycle request pulse from the master
//   fields    : wr/addr/wdata/wstrb valid with req
//   clr       : transaction for this master finished (ack or timeout)
//   pending   : a request is waiting or in flight
//   held      : fields captured at the accepted req
module regbus_req_hold
    import regbus_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic [REQ_W-1:0] req,
    input  req_fields_t      fields,
    input  logic             clr,
    output logic             pending,
    output req_fields_t      held
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= 1'b0;
            held    <= '0;
        end else begin
            if (clr) begin
                pending <= 1'b0;
            end
            // A req while already pending breaks the master protocol and is dropped,
            // so the captured fields of the in-flight request are never overwritten.
            if (req[0] && !pending) begin
                pending <= 1'b1;
                held    <= fields;
            end
        end
    end

endmodule

// File: rtl/regbus_arb.sv
// rtl/regbus_arb.sv - two-master round-robin arbiter with timeout watchdog for the register bus
//   clk, rstn             : clock, asynchronous active-low reset
//   m0_* / m1_*           : master ports (req pulse + fields in, ack/err/rdata out)
//   out_req/wr/addr/...   : request to the interconnect, fields held for the whole transaction
//   out_ack/err/rdata     : completion from the interconnect
//   timeout_evt           : one-cycle pulse when a master is answered by the watchdog
module regbus_arb
    import regbus_pkg::*;
#(
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter int                CNT_W          = $clog2(TIMEOUT_CYCLES + 1),
    parameter logic [DATA_W-1:0] ERR_RDATA      = 32'hDEADDEAD
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              out_req,
    output logic              out_wr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_wdata,
    output logic [STRB_W-1:0] out_wstrb,
    input  logic              out_ack,
    input  logic              out_err,
    input  logic [DATA_W-1:0] out_rdata,
    output logic              timeout_evt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    req_fields_t      m0_in, m1_in, h0, h1, sel_fields, out_f;
    logic [1:0]       pend, cand;
    logic             sel, grant, last_grant;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit, done;

    assign m0_in = '{wr: m0_wr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign m1_in = '{wr: m1_wr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

    assign timeout_hit = (cnt == CNT_LAST);
    assign done        = (state == S_WAIT) && (out_ack || timeout_hit);

    regbus_req_hold u_hold0 (
        .clk     (clk),
        .rstn    (rstn),
        .req     (m0_req),
        .fields  (m0_in),
        .clr     (done && !grant),
        .pending (pend[0]),
        .held    (h0)
    );

    regbus_req_hold u_hold1 (
        .clk     (clk),
        .rstn    (rstn),
        .req     (m1_req),
        .fields  (m1_in),
        .clr     (done && grant),
        .pending (pend[1]),
        .held    (h1)
    );

    // Round-robin pick; a req arriving this very cycle is not in the holding
    // register yet, so its fields are forwarded straight from the master inputs.
    always_comb begin
        cand = pend | {m1_req, m0_req};
        sel  = ~last_grant;
        if (!cand[sel]) begin
            sel = last_grant;
        end
        if (sel) begin
            sel_fields = (m1_req && !pend[1]) ? m1_in : h1;
        end else begin
            sel_fields = (m0_req && !pend[0]) ? m0_in : h0;
        end
    end

    assign out_wr    = out_f.wr;
    assign out_addr  = out_f.addr;
    assign out_wdata = out_f.wdata;
    assign out_wstrb = out_f.wstrb;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
            out_req     <= 1'b0;
            out_f       <= '0;
            m0_ack      <= 1'b0;
            m0_err      <= 1'b0;
            m0_rdata    <= '0;
            m1_ack      <= 1'b0;
            m1_err      <= 1'b0;
            m1_rdata    <= '0;
            timeout_evt <= 1'b0;
        end else begin
            out_req     <= 1'b0;
            m0_ack      <= 1'b0;
            m0_err      <= 1'b0;
            m1_ack      <= 1'b0;
            m1_err      <= 1'b0;
            timeout_evt <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|cand) begin
                        out_f   <= sel_fields;
                        out_req <= 1'b1;
                        grant   <= sel;
                        cnt     <= '0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // out_ack takes priority over a watchdog expiry in the same cycle.
                    if (done) begin
                        if (grant) begin
                            m1_ack   <= 1'b1;
                            m1_err   <= out_ack ? out_err : 1'b1;
                            m1_rdata <= out_ack ? out_rdata : ERR_RDATA;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_err   <= out_ack ? out_err : 1'b1;
                            m0_rdata <= out_ack ? out_rdata : ERR_RDATA;
                        end
                        timeout_evt <= !out_ack;
                        last_grant  <= grant;
                        state       <= out_ack ? S_IDLE : S_DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // The interconnect still owns the abandoned transaction; swallow
                    // its eventual completion before issuing anything new.
                    if (out_ack) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/regbus_arb.md
Name: regbus_arb

Overview:
- Two-master arbiter in front of the register-bus interconnect. It shares the single req/ack register port between master 0 (AXI bridge from the PS) and master 1 (on-fabric sequencer, e.g. DisplayPort link-training or debug command engine).
- Round-robin grant; address, data and control are latched at grant.
- A timeout watchdog answers the master with an error if the slave never acks, so a stuck peripheral cannot hang the CPU.
- Sits between the masters and the interconnect's `_out*` slave port.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles in WAIT without out_ack before the master receives an error ack. Legal range ≥ 2.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the watchdog counter.
- ERR_RDATA, 32'hDEADDEAD: rdata returned to the master on timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- m0_req  in  1  single-cycle request pulse
- m0_wr  in  1  1 = write, 0 = read
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_wstrb  in  4  byte strobes
- m0_ack  out  1  single-cycle completion pulse
- m0_err  out  1  valid with m0_ack
- m0_rdata  out  32  valid with m0_ack
- m1_req, m1_wr, m1_addr, m1_wdata, m1_wstrb, m1_ack, m1_err, m1_rdata: same widths and meanings as the m0_ ports, for master 1
- out_req  out  1  single-cycle request pulse to the interconnect
- out_wr  out  1  latched from the granted master
- out_addr  out  32  latched from the granted master
- out_wdata  out  32  latched from the granted master
- out_wstrb  out  4  latched from the granted master
- out_ack  in  1  completion pulse from the interconnect
- out_err  in  1  valid with out_ack
- out_rdata  in  32  valid with out_ack
- timeout_evt  out  1  single-cycle pulse when the watchdog fires (for a sticky status register elsewhere)

Behaviour:
- Reset values: all outputs 0; out_addr, out_wdata and m*_rdata are 0; state IDLE; pending = 0; last_grant = 1, so master 0 wins first.
- Master protocol:
  - A master pulses req for one cycle with addr/wdata/wr/wstrb valid in that cycle only; the arbiter captures them.
  - A master issues no new req until its ack. A req arriving while that master's pending bit is already set is ignored.
- Pending capture: m0_req or m1_req sets the corresponding pending bit, and a per-master holding register captures that master's request fields. Capture happens in any state.
- IDLE:
  - The candidate set is pending | {m1_req, m0_req}.
  - If non-empty: pick the master that is not last_grant if it is a candidate, else the sole candidate.
  - Load out_* from that master's captured fields, or directly from its inputs if its req arrives this cycle.
  - Next cycle: out_req = 1 for exactly one cycle; grant = selected; counter cleared; go to WAIT.
  - Minimum latency: req in cycle t, out_req in cycle t+1.
- WAIT:
  - out_* stay stable and the counter increments.
  - On out_ack, next cycle:
    - m<grant>_ack = 1, m<grant>_err = out_err, m<grant>_rdata = out_rdata;
    - clear pending[grant]; last_grant = grant; go to IDLE.
    - Ack latency is 1 cycle after out_ack.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1, next cycle:
    - m<grant>_ack = 1, err = 1, rdata = ERR_RDATA; timeout_evt = 1;
    - clear pending[grant]; last_grant = grant; go to DRAIN.
  - If out_ack and the timeout coincide in the same cycle, out_ack wins: normal completion, no timeout_evt.
- DRAIN:
  - out_* held stable, because the interconnect is still waiting on the slave.
  - No new out_req is issued; new master reqs only set pending.
  - On out_ack: discard err/rdata, no master ack, go to IDLE.
  - DRAIN has no timeout; it waits indefinitely.
- The ack pulses are mutually exclusive across masters, and out_req is never asserted outside the IDLE→WAIT transition.
- Reset mid-transaction aborts everything: pending cleared, no ack delivered, outputs return to reset values.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1…

Decomposition:
- Shared package `regbus_pkg`:
  - state encoding localparams S_IDLE=0, S_WAIT=1, S_DRAIN=2 (2-bit);
  - REQ_W=1, ADDR_W=32, DATA_W=32, STRB_W=4.
- One natural sub-module, `regbus_req_hold`: per-master pending bit plus captured-field holding register. Inputs are req/fields/clear; outputs are pending/fields. Instantiated twice.

Test Plan:
- Single read by m0, slave acks 2 cycles after out_req with rdata 32'h12345678: out_req 1 cycle after m0_req, out_addr = m0_addr; m0_ack 1 cycle after out_ack with rdata 32'h12345678 and err 0; m1_ack never asserted.
- m0_req and m1_req in the same cycle after reset: m0 granted first, m1's out_req follows the cycle after m0_ack; out_addr/wdata for the second transaction equal m1's captured values although m1 dropped its inputs after the pulse.
- Both masters re-requesting immediately after each ack for 8 transactions: grant order is exactly 0,1,0,1,0,1,0,1.
- TIMEOUT_CYCLES=16, slave never acks:
  - m0_ack with err=1, rdata=32'hDEADDEAD exactly 16 cycles after out_req, plus a one-cycle timeout_evt;
  - m1_req during DRAIN produces no out_req until out_ack arrives at cycle 40; that late ack produces no m0_ack, then m1 is served.
- out_ack in the same cycle the counter hits TIMEOUT_CYCLES-1: normal ack, err = out_err, no timeout_evt, state returns to IDLE.
- rstn asserted while in WAIT: all outputs 0 immediately (asynchronous); after release, a pending-free IDLE state, with no ack emitted for the aborted transaction.
